// File: rtl/vga_fb_arbiter_if.sv
// Host write channel and single-port pixel-memory bus of the VGA framebuffer arbiter.
// master is the arbiter; slave is the host writer together with the memory.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [DATA_W-1:0] host_wr_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  host_wr_valid, host_wr_addr, host_wr_data, mem_rdata,
    output host_wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output host_wr_valid, host_wr_addr, host_wr_data, mem_rdata,
    input  host_wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port pixel memory between display fetches (always win) and a
// FIFO-buffered host writer that drains whenever the display leaves the memory idle.
module vga_fb_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int H_VIS_START = 160,
  parameter int H_VIS_END   = 800,
  parameter int V_VIS_START = 41,
  parameter int V_VIS_END   = 521,
  parameter int FETCH_LEAD  = 3
) (
  input  logic              clk_25,
  input  logic              reset_n,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  vga_fb_arbiter_if.master  bus,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              frame_start,
  output logic [2:0]        fifo_level
);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int FETCH_LO  = H_VIS_START - FETCH_LEAD;
  localparam int FETCH_HI  = H_VIS_END - FETCH_LEAD;
  localparam logic [9:0] FETCH_START = FETCH_LO[9:0];
  localparam logic [9:0] FETCH_END   = FETCH_HI[9:0];
  localparam logic [9:0] V_START     = V_VIS_START[9:0];
  localparam logic [9:0] V_END       = V_VIS_END[9:0];
  localparam logic [PTR_W:0] FULL_LEVEL = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [1:0] {ST_VBLANK, ST_HBLANK, ST_FETCH} state_t;

  state_t                   state, state_next;
  logic                     v_vis, in_window, rd_now, push, pop;
  logic [ADDR_W-1:0]        disp_addr;
  logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [PTR_W:0]           count;
  logic                     rd_pend;

  assign v_vis     = (v_count >= V_START) && (v_count < V_END);
  assign in_window = v_vis && (h_count >= FETCH_START) && (h_count < FETCH_END);

  assign bus.host_wr_ready = (count != FULL_LEVEL);
  assign push       = bus.host_wr_valid && bus.host_wr_ready;
  assign pop        = !rd_now && (count != '0);
  assign fifo_level = count;

  // A fetch only starts at the head of the window, so a line entered mid-way
  // (e.g. after reset) stays dark until the next line begins.
  always_comb begin
    state_next = state;
    rd_now     = 1'b0;
    if (!v_vis) begin
      state_next = ST_VBLANK;
    end else begin
      case (state)
        ST_VBLANK: state_next = ST_HBLANK;
        ST_HBLANK: begin
          if (in_window && (h_count == FETCH_START)) begin
            state_next = ST_FETCH;
            rd_now     = 1'b1;
          end
        end
        ST_FETCH: begin
          if (in_window) rd_now = 1'b1;
          else           state_next = ST_HBLANK;
        end
        default: state_next = ST_VBLANK;
      endcase
    end
  end

  always_ff @(posedge clk_25) begin
    if (push) fifo_mem[wr_ptr] <= {bus.host_wr_addr, bus.host_wr_data};
  end

  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      state         <= ST_VBLANK;
      disp_addr     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      rd_pend       <= 1'b0;
      pix_valid     <= 1'b0;
      pix_data      <= '0;
      frame_start   <= 1'b0;
    end else begin
      state       <= state_next;
      frame_start <= (h_count == 10'd0) && (v_count == 10'd0);

      if (frame_start)  disp_addr <= '0;
      else if (rd_now)  disp_addr <= disp_addr + ADDR_W'(1);

      bus.mem_en <= rd_now || pop;
      bus.mem_we <= pop;
      if (rd_now) begin
        bus.mem_addr <= disp_addr;
      end else if (pop) begin
        bus.mem_addr  <= fifo_mem[rd_ptr][ADDR_W+DATA_W-1:DATA_W];
        bus.mem_wdata <= fifo_mem[rd_ptr][DATA_W-1:0];
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase

      // Memory answers one cycle after the read strobe; pixel lands one cycle later.
      rd_pend   <= bus.mem_en && !bus.mem_we;
      pix_valid <= rd_pend;
      pix_data  <= rd_pend ? bus.mem_rdata : '0;
    end
  end
endmodule
